// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam int unsigned DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_fsm_if.sv
// Switch-in / debounced-out signal bundle for debounce_fsm.
interface debounce_fsm_if;
  logic sw;
  logic db_level;
  logic db_tick;

  modport master (output sw, input  db_level, input  db_tick);
  modport slave  (input  sw, output db_level, output db_tick);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop input synchronizer; used by debounce_fsm only when DEBOUNCE_SYNC_EN is defined.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/debounce_fsm.sv
// Four-state switch debouncer with registered level and rising-edge tick.
// Define DEBOUNCE_SYNC_EN to place a 2-flop synchronizer ahead of the FSM.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  debounce_fsm_if.slave  bus
);
  localparam int unsigned   CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.sw),
    .q       (s)
  );
`else
  always_comb s = bus.sw;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = ZERO;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = ZERO;
        end
      end
      WAIT1: begin
        if (!s)            state_nxt = ZERO;
        else if (cnt == '0) state_nxt = ONE;
        else begin
          state_nxt = WAIT1;
          cnt_nxt   = cnt - CW'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = ONE;
        end
      end
      WAIT0: begin
        if (s)              state_nxt = ONE;
        else if (cnt == '0) state_nxt = ZERO;
        else begin
          state_nxt = WAIT0;
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.db_level <= 1'b0;
      bus.db_tick  <= 1'b0;
    end else begin
      bus.db_level <= (state_nxt == ONE) || (state_nxt == WAIT0);
      bus.db_tick  <= (state == WAIT1) && (state_nxt == ONE);
    end
  end
endmodule

// File: tb/tb_debounce_fsm.sv
// Randomized and directed checks of debounce_fsm against a run-length debounce model.
module tb_debounce_fsm;
  localparam int DB = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk;
  logic reset_n;
  debounce_fsm_if bus ();

  debounce_fsm #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the level flips once the sampled input has disagreed with it
  // on DB+1 consecutive edges; any agreeing sample clears the run.
  logic m_level, m_tick;
  int   m_run;
  logic q1, q2;

  task automatic cyc(input logic sv, input logic rv);
    logic s;
    bus.sw  = sv;
    reset_n = rv;
    @(posedge clk);
    if (!rv) begin
      m_level = 1'b0; m_tick = 1'b0; m_run = 0; q1 = 1'b0; q2 = 1'b0;
    end else begin
      s  = (SL != 0) ? q2 : sv;
      q2 = q1;
      q1 = sv;
      m_tick = 1'b0;
      if (s == m_level) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = s;
          m_tick  = s;
          m_run   = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic sv, input int n);
    for (int i = 0; i < n; i++) cyc(sv, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    total++;
    if ({bus.db_level, bus.db_tick} !== 2'b00) begin
      bad++;
      $display("FAIL reset: got lvl=%b tick=%b want lvl=0 tick=0", bus.db_level, bus.db_tick);
    end
  endtask

  task automatic test_clean_press();
    int tick_at = -1, ticks = 0;
    idle(1'b0, DB + SL + 3);
    for (int i = 0; i < 10 + SL; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
        bad++;
        $display("FAIL press_model cyc=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                 i, bus.db_level, bus.db_tick, m_level, m_tick);
      end
      if (bus.db_tick === 1'b1) begin ticks++; tick_at = i; end
    end
    total++;
    if (ticks != 1 || tick_at != DB + SL) begin
      bad++;
      $display("FAIL press_latency: got ticks=%0d at=%0d want ticks=1 at=%0d", ticks, tick_at, DB + SL);
    end
    total++;
    if (bus.db_level !== 1'b1) begin
      bad++;
      $display("FAIL press_level: got %b want 1", bus.db_level);
    end
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int tick_at = -1, ticks = 0;
    logic v;
    idle(1'b0, DB + SL + 3);
    for (int i = 0; i < 5 + DB + SL + 4; i++) begin
      v = (i < 5) ? pat[i] : 1'b1;
      cyc(v, 1'b1);
      total++;
      if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
        bad++;
        $display("FAIL bounce_model cyc=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                 i, bus.db_level, bus.db_tick, m_level, m_tick);
      end
      if (bus.db_tick === 1'b1) begin ticks++; tick_at = i; end
    end
    total++;
    if (ticks != 1 || tick_at != 4 + DB + SL) begin
      bad++;
      $display("FAIL bounce_tick: got ticks=%0d at=%0d want ticks=1 at=%0d", ticks, tick_at, 4 + DB + SL);
    end
  endtask

  task automatic test_release_glitch();
    logic v;
    int drops = 0, ticks = 0;
    for (int i = 0; i < 10 + SL; i++) begin
      v = (i < 2) ? 1'b0 : 1'b1;
      cyc(v, 1'b1);
      total++;
      if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
        bad++;
        $display("FAIL glitch_model cyc=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                 i, bus.db_level, bus.db_tick, m_level, m_tick);
      end
      if (bus.db_level !== 1'b1) drops++;
      if (bus.db_tick !== 1'b0) ticks++;
    end
    total++;
    if (drops != 0 || ticks != 0) begin
      bad++;
      $display("FAIL glitch_hold: got drops=%0d ticks=%0d want drops=0 ticks=0", drops, ticks);
    end
  endtask

  task automatic test_full_release();
    int fall_at = -1, ticks = 0;
    for (int i = 0; i < 8 + SL; i++) begin
      cyc(1'b0, 1'b1);
      total++;
      if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
        bad++;
        $display("FAIL release_model cyc=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                 i, bus.db_level, bus.db_tick, m_level, m_tick);
      end
      if (bus.db_level === 1'b0 && fall_at < 0) fall_at = i;
      if (bus.db_tick !== 1'b0) ticks++;
    end
    total++;
    if (fall_at != DB + SL || ticks != 0) begin
      bad++;
      $display("FAIL release_latency: got fall_at=%0d ticks=%0d want fall_at=%0d ticks=0", fall_at, ticks, DB + SL);
    end
  endtask

  task automatic test_reset_mid_wait1();
    int tick_at = -1, ticks = 0;
    idle(1'b0, DB + SL + 3);
    for (int i = 0; i < 3 + SL; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    total++;
    if ({bus.db_level, bus.db_tick} !== 2'b00) begin
      bad++;
      $display("FAIL midreset_outputs: got lvl=%b tick=%b want lvl=0 tick=0", bus.db_level, bus.db_tick);
    end
    for (int j = 0; j < 8 + SL; j++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
        bad++;
        $display("FAIL midreset_model cyc=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                 j, bus.db_level, bus.db_tick, m_level, m_tick);
      end
      if (bus.db_tick === 1'b1) begin ticks++; tick_at = j; end
    end
    total++;
    if (ticks != 1 || tick_at != DB + SL) begin
      bad++;
      $display("FAIL midreset_tick: got ticks=%0d at=%0d want ticks=1 at=%0d", ticks, tick_at, DB + SL);
    end
  endtask

  task automatic test_random();
    logic v, r;
    int len;
    for (int b = 0; b < 80; b++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, DB + SL + 3));
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
        cyc(v, r);
        total++;
        if ({bus.db_level, bus.db_tick} !== {m_level, m_tick}) begin
          bad++;
          $display("FAIL random_model burst=%0d k=%0d: got lvl=%b tick=%b want lvl=%b tick=%b",
                   b, k, bus.db_level, bus.db_tick, m_level, m_tick);
        end
      end
    end
  endtask

  initial begin
    bus.sw  = 1'b0;
    reset_n = 1'b0;
    m_level = 1'b0; m_tick = 1'b0; m_run = 0; q1 = 1'b0; q2 = 1'b0;
    test_reset();
    test_clean_press();
    test_full_release();
    test_bounce();
    test_release_glitch();
    test_full_release();
    test_reset_mid_wait1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
